// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator dispatch scheduler.
//   state_e      : scheduler state (Idle, Move, Door)
//   Def*         : default build constants
//   any_above    : any pending call strictly above the one-hot floor
//   any_below    : any pending call strictly below the one-hot floor
//   prefer_up    : with calls on both sides, 1 when the nearest is above (ties go up)
// Vectors are passed zero-extended to MaxFloors bits so one set of helpers
// serves any FLOORS value.
package elevator_pkg;

    localparam int unsigned DefFloors       = 5;
    localparam int unsigned DefTravelCycles = 100_000_000;
    localparam int unsigned DefDoorCycles   = 250_000_000;
    localparam int          MaxFloors       = 32;

    typedef logic [MaxFloors-1:0] floor_vec_t;

    typedef enum logic [1:0] {
        Idle,
        Move,
        Door
    } state_e;

    // (floor << 1) - 1 is a mask of the current floor and everything below it.
    function automatic logic any_above(floor_vec_t pending, floor_vec_t floor_oh);
        return |(pending & ~((floor_oh << 1) - floor_vec_t'(1)));
    endfunction

    function automatic logic any_below(floor_vec_t pending, floor_vec_t floor_oh);
        return |(pending & (floor_oh - floor_vec_t'(1)));
    endfunction

    function automatic logic prefer_up(floor_vec_t pending, floor_vec_t floor_oh);
        int cur;
        int up_idx;
        int dn_idx;
        cur    = 0;
        up_idx = MaxFloors;
        dn_idx = 0;
        for (int i = 0; i < MaxFloors; i++) begin
            if (floor_oh[i]) cur = i;
        end
        // Lowest call above the car.
        for (int i = MaxFloors - 1; i >= 0; i--) begin
            if (pending[i] && (i > cur)) up_idx = i;
        end
        // Highest call below the car.
        for (int i = 0; i < MaxFloors; i++) begin
            if (pending[i] && (i < cur)) dn_idx = i;
        end
        return (up_idx - cur) <= (cur - dn_idx);
    endfunction

endpackage

// File: rtl/elevator_call_latch.sv
// Button capture for one bank of call buttons.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   btn_ni  : active-low buttons, asynchronous to clk_i
//   clr_i   : per-floor clear (call serviced)
//   pend_o  : registered pending calls, also used as the lamp drive
// Each button goes through a 2-FF synchronizer; only the press edge sets the
// pending bit, so a held button cannot re-arm a call after it is serviced.
module elevator_call_latch #(
    parameter int unsigned Width = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] btn_ni,
    input  logic [Width-1:0] clr_i,
    output logic [Width-1:0] pend_o
);

    logic [Width-1:0] sync1_q, sync2_q, prev_q, pend_q, pend_d;
    logic [Width-1:0] press;

    // A new press wins over a same-cycle clear so it is never dropped.
    assign press  = sync2_q & ~prev_q;
    assign pend_d = (pend_q & ~clr_i) | press;
    assign pend_o = pend_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
        end else begin
            sync1_q <= ~btn_ni;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: rtl/elevator_dispatch_scheduler.sv
// Collective (SCAN) scheduler for a single car.
//   clk           : system clock, rising edge
//   resetn        : asynchronous active-low reset
//   request_out   : hall call buttons, active-low, asynchronous
//   request_in    : car call buttons, active-low, asynchronous
//   current_floor : one-hot car position (floor 1 = bit 0)
//   lamp_out      : pending hall calls
//   lamp_in       : pending car calls
//   door_open     : door dwell in progress
//   moving        : car travelling between floors
//   dir_up        : current/last travel direction
// Optional feature: define ELEV_SCHED_HOME_EN to return an idle car to floor 1
// after HOME_CYCLES idle cycles (CNT_W must then hold HOME_CYCLES).
module elevator_dispatch_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned FLOORS        = DefFloors,
    parameter int unsigned TRAVEL_CYCLES = DefTravelCycles,
    parameter int unsigned DOOR_CYCLES   = DefDoorCycles,
    parameter int unsigned CNT_W         = 28,
    parameter int unsigned HOME_CYCLES   = 500_000_000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [FLOORS-1:0] request_out,
    input  logic [FLOORS-1:0] request_in,
    output logic [FLOORS-1:0] current_floor,
    output logic [FLOORS-1:0] lamp_out,
    output logic [FLOORS-1:0] lamp_in,
    output logic              door_open,
    output logic              moving,
    output logic              dir_up
);

    state_e            state_q, state_d;
    logic [FLOORS-1:0] floor_q, floor_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic              dir_up_q, dir_up_d;
    logic              door_q, door_d;
    logic              moving_q, moving_d;
    logic              homing_q, homing_d;
    logic [FLOORS-1:0] clr, pend_in, pend_out, pending, next_floor;
    logic              here, above, below, ahead, behind;
    logic              arr_here, arr_ahead, arr_behind, travel_end, door_end;

    elevator_call_latch #(.Width(FLOORS)) u_latch_in (
        .clk_i  (clk),
        .rst_ni (resetn),
        .btn_ni (request_in),
        .clr_i  (clr),
        .pend_o (pend_in)
    );

    elevator_call_latch #(.Width(FLOORS)) u_latch_out (
        .clk_i  (clk),
        .rst_ni (resetn),
        .btn_ni (request_out),
        .clr_i  (clr),
        .pend_o (pend_out)
    );

    assign pending    = pend_in | pend_out;
    assign next_floor = dir_up_q ? (floor_q << 1) : (floor_q >> 1);
    assign here       = |(pending & floor_q);
    assign above      = any_above(floor_vec_t'(pending), floor_vec_t'(floor_q));
    assign below      = any_below(floor_vec_t'(pending), floor_vec_t'(floor_q));
    assign ahead      = dir_up_q ? above : below;
    assign behind     = dir_up_q ? below : above;
    // Arrival decisions look at the floor being entered so the stop and the
    // call clear happen on the same edge as the position update.
    assign arr_here   = |(pending & next_floor);
    assign arr_ahead  = dir_up_q ? any_above(floor_vec_t'(pending), floor_vec_t'(next_floor))
                                 : any_below(floor_vec_t'(pending), floor_vec_t'(next_floor));
    assign arr_behind = dir_up_q ? any_below(floor_vec_t'(pending), floor_vec_t'(next_floor))
                                 : any_above(floor_vec_t'(pending), floor_vec_t'(next_floor));
    assign travel_end = (timer_q == CNT_W'(TRAVEL_CYCLES - 1));
    assign door_end   = (timer_q == CNT_W'(DOOR_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        timer_d  = timer_q;
        dir_up_d = dir_up_q;
        homing_d = homing_q;
        clr      = '0;
        unique case (state_q)
            Idle: begin
                timer_d  = '0;
                homing_d = 1'b0;
                if (here) begin
                    clr     = floor_q;
                    state_d = Door;
                end else if (above && (!below ||
                             prefer_up(floor_vec_t'(pending), floor_vec_t'(floor_q)))) begin
                    state_d  = Move;
                    dir_up_d = 1'b1;
                end else if (below) begin
                    state_d  = Move;
                    dir_up_d = 1'b0;
                end
`ifdef ELEV_SCHED_HOME_EN
                else if (!floor_q[0]) begin
                    if (timer_q == CNT_W'(HOME_CYCLES - 1)) begin
                        state_d  = Move;
                        dir_up_d = 1'b0;
                        homing_d = 1'b1;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
`endif
            end
            Move: begin
                if (travel_end) begin
                    floor_d  = next_floor;
                    timer_d  = '0;
                    // Any real call supersedes homing from here on.
                    homing_d = homing_q && (pending == '0);
                    if (arr_here) begin
                        clr     = next_floor;
                        state_d = Door;
                    end else if (arr_ahead) begin
                        state_d = Move;
                    end else if (arr_behind) begin
                        dir_up_d = ~dir_up_q;
                    end else if (homing_q && !next_floor[0]) begin
                        state_d = Move;
                    end else begin
                        state_d = Idle;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            Door: begin
                if (here) begin
                    clr     = floor_q;
                    timer_d = '0;
                end else if (door_end) begin
                    timer_d = '0;
                    if (ahead) begin
                        state_d = Move;
                    end else if (behind) begin
                        state_d  = Move;
                        dir_up_d = ~dir_up_q;
                    end else begin
                        state_d = Idle;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            default: state_d = Idle;
        endcase
        door_d   = (state_d == Door);
        moving_d = (state_d == Move);
    end

`ifndef ELEV_SCHED_HOME_EN
    logic unused_home;
    assign unused_home = ^HOME_CYCLES;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= Idle;
            floor_q  <= FLOORS'(1);
            timer_q  <= '0;
            dir_up_q <= 1'b1;
            door_q   <= 1'b0;
            moving_q <= 1'b0;
            homing_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            timer_q  <= timer_d;
            dir_up_q <= dir_up_d;
            door_q   <= door_d;
            moving_q <= moving_d;
            homing_q <= homing_d;
        end
    end

    assign current_floor = floor_q;
    assign lamp_out      = pend_out;
    assign lamp_in       = pend_in;
    assign door_open     = door_q;
    assign moving        = moving_q;
    assign dir_up        = dir_up_q;

endmodule

// File: tb/tb_elevator_dispatch_scheduler.sv
// Self-checking bench for elevator_dispatch_scheduler (TRAVEL=4, DOOR=6, HOME=20).
// Expected floor/door events are queued as stimulus is applied and a monitor
// pops and compares them whenever the car position or door state changes.
module tb_elevator_dispatch_scheduler;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [4:0] request_out = 5'b11111;
    logic [4:0] request_in = 5'b11111;
    logic [4:0] current_floor, lamp_out, lamp_in;
    logic       door_open, moving, dir_up;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [4:0] floor;
        logic       door;
        int         gap;   // cycles since previous event, -1 = not checked
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    bit         mon_en = 1'b0;
    logic [4:0] last_floor;
    logic       last_door;
    int         gap = 0;

    always #5 clk = ~clk;

    elevator_dispatch_scheduler #(
        .FLOORS        (5),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (6),
        .CNT_W         (8),
        .HOME_CYCLES   (20)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .request_out   (request_out),
        .request_in    (request_in),
        .current_floor (current_floor),
        .lamp_out      (lamp_out),
        .lamp_in       (lamp_in),
        .door_open     (door_open),
        .moving        (moving),
        .dir_up        (dir_up)
    );

    always @(negedge clk) begin
        if (mon_en) begin
            gap++;
            if ((current_floor !== last_floor) || (door_open !== last_door)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event: got floor=%b door=%b gap=%0d, required none",
                             current_floor, door_open, gap);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ((current_floor !== mon_e.floor) || (door_open !== mon_e.door) ||
                        ((mon_e.gap >= 0) && (gap != mon_e.gap))) begin
                        n_err++;
                        $display("FAIL event: got floor=%b door=%b gap=%0d, required floor=%b door=%b gap=%0d",
                                 current_floor, door_open, gap, mon_e.floor, mon_e.door, mon_e.gap);
                    end
                end
                gap = 0;
            end
        end else begin
            gap = 0;
        end
        last_floor = current_floor;
        last_door  = door_open;
    end

    task automatic push(input logic [4:0] floor, input logic door, input int g);
        ev_t e;
        e.floor = floor;
        e.door  = door;
        e.gap   = g;
        exp_q.push_back(e);
    endtask

    // One-cycle press of the buttons selected by the masks.
    task automatic press(input logic [4:0] in_m, input logic [4:0] out_m);
        @(negedge clk);
        request_in  = ~in_m;
        request_out = ~out_m;
        @(negedge clk);
        request_in  = 5'b11111;
        request_out = 5'b11111;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d events still outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({current_floor, lamp_out, lamp_in, door_open, moving, dir_up} !==
            {5'b00001, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_values: got fl=%b lo=%b li=%b d=%b m=%b up=%b, required 00001 0 0 0 0 1",
                     current_floor, lamp_out, lamp_in, door_open, moving, dir_up);
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({current_floor, door_open, moving} !== {5'b00001, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_idle: got fl=%b d=%b m=%b, required 00001 0 0",
                     current_floor, door_open, moving);
        end
    endtask

    task automatic test_single();
        mon_en = 1'b1;
        push(5'b00010, 1'b0, -1);
        push(5'b00100, 1'b1, 4);
        push(5'b00100, 1'b0, 6);
        press(5'b00100, 5'b00000);
        @(negedge clk);
        n_cmp++;
        if (lamp_in !== 5'b00000) begin
            n_err++;
            $display("FAIL lamp_early: got %b, required 00000", lamp_in);
        end
        @(negedge clk);
        n_cmp++;
        if (lamp_in !== 5'b00100) begin
            n_err++;
            $display("FAIL lamp_at_3: got %b, required 00100", lamp_in);
        end
        drain(80);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({current_floor, lamp_in, door_open, moving} !== {5'b00100, 5'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL single_idle: got fl=%b li=%b d=%b m=%b, required 00100 00000 0 0",
                     current_floor, lamp_in, door_open, moving);
        end
    endtask

    task automatic test_tie_break();
        push(5'b01000, 1'b0, -1);
        push(5'b10000, 1'b1, 4);
        push(5'b10000, 1'b0, 6);
        push(5'b01000, 1'b0, 4);
        push(5'b00100, 1'b0, 4);
        push(5'b00010, 1'b0, 4);
        push(5'b00001, 1'b1, 4);
        push(5'b00001, 1'b0, 6);
        press(5'b10001, 5'b00000);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (lamp_in !== 5'b10001) begin
            n_err++;
            $display("FAIL tie_lamps: got %b, required 10001", lamp_in);
        end
        @(negedge clk);
        n_cmp++;
        if ({moving, dir_up} !== 2'b11) begin
            n_err++;
            $display("FAIL tie_dir: got moving=%b dir_up=%b, required 1 1", moving, dir_up);
        end
        drain(150);
    endtask

    task automatic test_scan_pickup();
        push(5'b00010, 1'b0, -1);
        push(5'b00100, 1'b1, 4);
        push(5'b00100, 1'b0, 6);
        push(5'b01000, 1'b0, 4);
        push(5'b10000, 1'b1, 4);
        push(5'b10000, 1'b0, 6);
        press(5'b10000, 5'b00000);
        press(5'b00000, 5'b00100);
        drain(120);
        n_cmp++;
        if ({lamp_in, lamp_out} !== 10'b0) begin
            n_err++;
            $display("FAIL scan_lamps: got li=%b lo=%b, required 0 0", lamp_in, lamp_out);
        end
    endtask

    task automatic test_same_floor();
        int cnt;
        push(5'b01000, 1'b0, -1);
        push(5'b00100, 1'b0, 4);
        push(5'b00010, 1'b1, 4);
        push(5'b00010, 1'b0, 6);
        press(5'b00010, 5'b00000);
        drain(100);
        push(5'b00010, 1'b1, -1);
        push(5'b00010, 1'b0, 11);
        press(5'b00000, 5'b00010);
        cnt = 0;
        while (door_open !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if ({door_open, moving, current_floor} !== {1'b1, 1'b0, 5'b00010}) begin
            n_err++;
            $display("FAIL same_floor_open: got d=%b m=%b fl=%b, required 1 0 00010",
                     door_open, moving, current_floor);
        end
        press(5'b00000, 5'b00010);
        cnt = 0;
        while (door_open !== 1'b0 && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if (cnt != 9) begin
            n_err++;
            $display("FAIL dwell_restart: got %0d cycles to close, required 9", cnt);
        end
        drain(20);
        n_cmp++;
        if ({current_floor, moving, lamp_out} !== {5'b00010, 1'b0, 5'b0}) begin
            n_err++;
            $display("FAIL same_floor_end: got fl=%b m=%b lo=%b, required 00010 0 00000",
                     current_floor, moving, lamp_out);
        end
    endtask

    task automatic test_homing();
        push(5'b00100, 1'b0, -1);
        push(5'b01000, 1'b1, 4);
        push(5'b01000, 1'b0, 6);
`ifdef ELEV_SCHED_HOME_EN
        push(5'b00100, 1'b0, 24);
        push(5'b00010, 1'b0, 4);
        push(5'b00001, 1'b0, 4);
        press(5'b01000, 5'b00000);
        drain(200);
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({current_floor, door_open, moving} !== {5'b00001, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL homing_end: got fl=%b d=%b m=%b, required 00001 0 0",
                     current_floor, door_open, moving);
        end
`else
        press(5'b01000, 5'b00000);
        drain(100);
        repeat (60) @(negedge clk);
        n_cmp++;
        if ({current_floor, door_open, moving} !== {5'b01000, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL parked: got fl=%b d=%b m=%b, required 01000 0 0",
                     current_floor, door_open, moving);
        end
`endif
    endtask

    task automatic test_reset_mid();
        mon_en = 1'b0;
        press(5'b10000, 5'b00000);
        repeat (10) @(negedge clk);
        n_cmp++;
        if ((moving | door_open) !== 1'b1) begin
            n_err++;
            $display("FAIL mid_busy: got moving=%b door=%b, required busy", moving, door_open);
        end
        press(5'b00000, 5'b00100);
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({current_floor, lamp_out, lamp_in, door_open, moving, dir_up} !==
            {5'b00001, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL mid_reset: got fl=%b lo=%b li=%b d=%b m=%b up=%b, required 00001 0 0 0 0 1",
                     current_floor, lamp_out, lamp_in, door_open, moving, dir_up);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (12) @(negedge clk);
        n_cmp++;
        if ({current_floor, lamp_out, lamp_in, moving, door_open} !==
            {5'b00001, 5'b0, 5'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL calls_lost: got fl=%b lo=%b li=%b m=%b d=%b, required 00001 0 0 0 0",
                     current_floor, lamp_out, lamp_in, moving, door_open);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie_break();
        test_scan_pickup();
        test_same_floor();
        test_homing();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
